// File: rtl/pusch_rx_pkg.sv
// Shared types and constants for the PUSCH receive demapper.
// Holds the FSM encoding, the supported modulation orders and the decision thresholds.
package pusch_rx_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

    // Qm=8 does not fit the 3-bit order field, so 256QAM is carried as 3'd0.
    localparam logic [2:0] QM_BPSK   = 3'd1;
    localparam logic [2:0] QM_QPSK   = 3'd2;
    localparam logic [2:0] QM_16QAM  = 3'd4;
    localparam logic [2:0] QM_64QAM  = 3'd6;
    localparam logic [2:0] QM_256QAM = 3'd0;

    localparam int U_QPSK = 23170;
    localparam int U_16   = 20724;
    localparam int U_64   = 10112;
    localparam int U_256  = 5026;

    function automatic logic qm_supported(input logic [2:0] qm);
        logic ok;
        case (qm)
            QM_BPSK, QM_QPSK, QM_16QAM, QM_64QAM, QM_256QAM: ok = 1'b1;
            default:                                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Index of the final bit; the 3-bit wrap maps the 256QAM code 0 to bit 7.
    function automatic logic [2:0] qm_last_idx(input logic [2:0] qm);
        return qm - 3'd1;
    endfunction

endpackage

// File: rtl/demap_decide.sv
// Combinational hard-decision demapper: latched I/Q and Qm to an 8-bit word, bit k = b_k.
// Higher-order bits come from nested folding of |I| (even bits) and |Q| (odd bits).
module demap_decide
    import pusch_rx_pkg::*;
#(
    parameter int IN_WIDTH = 18
) (
    input  logic signed [IN_WIDTH-1:0] i_in,
    input  logic signed [IN_WIDTH-1:0] q_in,
    input  logic        [2:0]          qm,
    output logic        [7:0]          dec_word
);

    localparam int W = IN_WIDTH;
    localparam logic signed [W:0] ZERO_S = '0;

    logic signed [W:0]   sum_iq;
    logic        [W-1:0] thr0, thr1, thr2;
    logic        [W-1:0] ti0, ti1, ti2;
    logic        [W-1:0] tq0, tq1, tq2;
    logic        [7:0]   raw;
    logic        [7:0]   mask;

    function automatic logic [W-1:0] mag(input logic signed [W-1:0] x);
        logic [W-1:0] ux;
        ux = x;
        return x[W-1] ? (~ux + W'(1)) : ux;
    endfunction

    // Returns {t > thr, |t - thr|}; a tie decides 0.
    function automatic logic [W:0] fold(input logic [W-1:0] t, input logic [W-1:0] thr);
        return (t > thr) ? {1'b1, t - thr} : {1'b0, thr - t};
    endfunction

    // Sign-extend before adding so the BPSK sum cannot overflow.
    assign sum_iq = {i_in[W-1], i_in} + {q_in[W-1], q_in};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        thr0 = '0;
        mask = '0;
        case (qm)
            QM_BPSK:   mask = 8'h01;
            QM_QPSK:   mask = 8'h03;
            QM_16QAM:  begin thr0 = W'(U_16 * 2);  mask = 8'h0F; end
            QM_64QAM:  begin thr0 = W'(U_64 * 4);  mask = 8'h3F; end
            QM_256QAM: begin thr0 = W'(U_256 * 8); mask = 8'hFF; end
            default:   mask = 8'h00;
        endcase
        thr1 = thr0 >> 1;
        thr2 = thr0 >> 2;

        raw    = '0;
        raw[0] = (qm == QM_BPSK) ? (sum_iq < ZERO_S) : i_in[W-1];
        raw[1] = q_in[W-1];

        ti0 = mag(i_in);
        {raw[2], ti1} = fold(ti0, thr0);
        {raw[4], ti2} = fold(ti1, thr1);
        raw[6] = ti2 > thr2;

        tq0 = mag(q_in);
        {raw[3], tq1} = fold(tq0, thr0);
        {raw[5], tq2} = fold(tq1, thr1);
        raw[7] = tq2 > thr2;

        dec_word = raw & mask;
    end

endmodule

// File: rtl/demapper_rx.sv
// Hard-decision demapper top: handshake FSM, bit serializer and symbol counter.
// One accepted I/Q sample becomes Qm contiguous Serial_OUT bits, b0 first.
module demapper_rx
    import pusch_rx_pkg::*;
#(
    parameter int IN_WIDTH  = 18,
    parameter int CNT_WIDTH = 11
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [IN_WIDTH-1:0]  Demap_IN_I,
    input  logic signed [IN_WIDTH-1:0]  Demap_IN_Q,
    input  logic                        Valid_IN,
    output logic                        Ready_OUT,
    input  logic                        Last_IN,
    input  logic        [2:0]           Order_Demap,
    output logic                        Serial_OUT,
    output logic                        Valid_OUT,
    output logic                        Last_OUT,
    output logic        [CNT_WIDTH-1:0] Sym_Count,
    output logic                        Err_Order
);

    state_t                       state_q, state_d;
    logic signed [IN_WIDTH-1:0]   i_q, i_d;
    logic signed [IN_WIDTH-1:0]   q_q, q_d;
    logic        [2:0]            qm_q, qm_d;
    logic                         last_q, last_d;
    logic        [2:0]            bit_idx_q, bit_idx_d;
    logic        [CNT_WIDTH-1:0]  sym_count_q, sym_count_d;
    logic                         err_order_q, err_order_d;
    logic                         run_q, run_d;

    logic [7:0] dec_word;
    logic       in_shift;
    logic       last_bit;
    logic       accept;
    logic       accept_ok;

    demap_decide #(
        .IN_WIDTH (IN_WIDTH)
    ) u_decide (
        .i_in     (i_q),
        .q_in     (q_q),
        .qm       (qm_q),
        .dec_word (dec_word)
    );

    assign in_shift  = (state_q == ST_SHIFT);
    assign last_bit  = in_shift && (bit_idx_q == qm_last_idx(qm_q));
    // run_q holds Ready_OUT low while in reset and releases it one clock later.
    assign Ready_OUT = run_q && (!in_shift || last_bit);
    assign accept    = Valid_IN && Ready_OUT;
    assign accept_ok = accept && qm_supported(Order_Demap);

    assign Valid_OUT  = in_shift;
    assign Serial_OUT = in_shift && dec_word[bit_idx_q];
    assign Last_OUT   = last_bit && last_q;
    assign Sym_Count  = sym_count_q;
    assign Err_Order  = err_order_q;

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        q_d         = q_q;
        qm_d        = qm_q;
        last_d      = last_q;
        bit_idx_d   = bit_idx_q;
        sym_count_d = sym_count_q;
        run_d       = 1'b1;
        err_order_d = accept && !qm_supported(Order_Demap);

        if (accept_ok) begin
            state_d   = ST_SHIFT;
            i_d       = Demap_IN_I;
            q_d       = Demap_IN_Q;
            qm_d      = Order_Demap;
            last_d    = Last_IN;
            bit_idx_d = '0;
        end else if (in_shift) begin
            if (last_bit) begin
                state_d = ST_IDLE;
            end else begin
                bit_idx_d = bit_idx_q + 3'd1;
            end
        end

        // The block ends with Last_OUT; a symbol taken in that same cycle opens the next block.
        if (Last_OUT) begin
            sym_count_d = accept_ok ? CNT_WIDTH'(1) : '0;
        end else if (accept_ok) begin
            sym_count_d = sym_count_q + CNT_WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            i_q         <= '0;
            q_q         <= '0;
            qm_q        <= '0;
            last_q      <= 1'b0;
            bit_idx_q   <= '0;
            sym_count_q <= '0;
            err_order_q <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            q_q         <= q_d;
            qm_q        <= qm_d;
            last_q      <= last_d;
            bit_idx_q   <= bit_idx_d;
            sym_count_q <= sym_count_d;
            err_order_q <= err_order_d;
            run_q       <= run_d;
        end
    end

endmodule
